fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the core's decode/execute logic. It owns the fetch PC and issues sequential word requests on the instruction-memory ready/valid port. It buffers in-order responses tagged with their PC and hands them downstream over a valid/ready port. On a redirect (jump or taken branch) it discards stale in-flight responses, so memory never sees an illegal cancel.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: sequential PC requests, in-order response buffer, redirect flush
// Stale responses left over from a redirect are counted down and dropped; memory never sees a cancel.
module fetch_unit #(
   parameter int Xlen = 32,
   parameter int Ilen = 32,
   parameter int DepthLog2 = 2,
   parameter logic [Xlen-1:0] ResetPc = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              redirect_valid_i,
   input  logic [Xlen-1:0]   redirect_pc_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [Xlen-1:0]   inst_pc_o,
   output logic [Ilen-1:0]   inst_data_o,
   input  logic              instmem_ready_i,
   output logic              instmem_valid_o,
   output logic [Xlen-1:0]   instmem_addr_o,
   output logic [Ilen-1:0]   instmem_wdata_o,
   output logic [Ilen/8-1:0] instmem_wmask_o,
   input  logic [Ilen-1:0]   instmem_rdata_i,
   input  logic              instmem_rvalid_i
);

   localparam int Depth = 2 ** DepthLog2;
   localparam int Cw = DepthLog2 + 1;

   logic                 run_q;
   logic [Xlen-1:0]      pc_q;
   logic [Xlen-1:0]      resp_pc_q;
   logic [Cw-1:0]        count_q;
   logic [Cw-1:0]        inflight_q;
   logic [Cw-1:0]        stale_q;
   logic [DepthLog2-1:0] wr_ptr_q;
   logic [DepthLog2-1:0] rd_ptr_q;
   logic [Xlen+Ilen-1:0] buf_q [Depth];

   logic [Xlen-1:0] target;
   logic [Cw-1:0]   eff_count;
   logic [Cw:0]     occupancy;
   logic            credit;
   logic            accept;
   logic            push;
   logic            pop;
   logic            unused_pc_lsbs;

   assign target         = {redirect_pc_i[Xlen-1:2], 2'b00};
   assign unused_pc_lsbs = ^redirect_pc_i[1:0];

   // A redirect flushes the buffer this cycle, so its entries no longer hold credit.
   assign eff_count = redirect_valid_i ? '0 : count_q;
   assign occupancy = {1'b0, inflight_q} + {1'b0, eff_count};
   assign credit    = run_q && (occupancy < (Cw+1)'(Depth));
   assign accept    = credit && instmem_ready_i;

   assign push = instmem_rvalid_i && !redirect_valid_i && (stale_q == '0);
   assign pop  = (count_q != '0) && inst_ready_i && !redirect_valid_i;

   assign instmem_valid_o = credit;
   assign instmem_addr_o  = redirect_valid_i ? target : pc_q;
   assign instmem_wdata_o = '0;
   assign instmem_wmask_o = '0;

   assign inst_valid_o             = (count_q != '0);
   assign {inst_pc_o, inst_data_o} = buf_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_q      <= 1'b0;
         pc_q       <= ResetPc;
         resp_pc_q  <= ResetPc;
         count_q    <= '0;
         inflight_q <= '0;
         stale_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         run_q <= 1'b1;

         if (accept) begin
            pc_q <= instmem_addr_o + Xlen'(4);
         end else if (redirect_valid_i) begin
            pc_q <= target;
         end

         inflight_q <= inflight_q + Cw'(accept) - Cw'(instmem_rvalid_i);

         // Everything still outstanding after this cycle's response belongs to the old path.
         if (redirect_valid_i) begin
            stale_q <= inflight_q - Cw'(instmem_rvalid_i);
         end else if (instmem_rvalid_i && (stale_q != '0)) begin
            stale_q <= stale_q - Cw'(1);
         end

         if (redirect_valid_i) begin
            resp_pc_q <= target;
         end else if (push) begin
            resp_pc_q <= resp_pc_q + Xlen'(4);
         end

         if (redirect_valid_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + DepthLog2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DepthLog2'(1);
            count_q <= count_q + Cw'(push) - Cw'(pop);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_q[wr_ptr_q] <= {resp_pc_q, instmem_rdata_i};
      end
   end

   push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && (count_q == Cw'(Depth))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with queue-based reference model and latency-programmable memory
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        mem_ready = 1'b1;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .inst_valid_o     (inst_valid),
      .inst_ready_i     (inst_ready),
      .inst_pc_o        (inst_pc),
      .inst_data_o      (inst_data),
      .instmem_ready_i  (mem_ready),
      .instmem_valid_o  (mem_valid),
      .instmem_addr_o   (mem_addr),
      .instmem_wdata_o  (mem_wdata),
      .instmem_wmask_o  (mem_wmask),
      .instmem_rdata_i  (mem_rdata),
      .instmem_rvalid_i (mem_rvalid)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      logic [31:0] r;
      r = (a * 32'h0001_0003) ^ 32'hC0DE_0000;
      return r;
   endfunction

   task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Memory: in-order responses, programmable latency, never two in one cycle.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;
   req_t pend[$];
   int   cyc = 0;
   int   lat = 1;
   int   last_due = 0;
   int   due_tmp;

   always @(negedge clk) begin
      if (rst_ni && mem_valid && mem_ready) begin
         due_tmp = cyc + lat;
         if (due_tmp <= last_due) due_tmp = last_due + 1;
         pend.push_back('{mem_addr, due_tmp});
         last_due = due_tmp;
      end
   end

   always @(posedge clk) begin
      cyc++;
      #1;
      if (!rst_ni) begin
         pend.delete();
         last_due = 0;
         mem_rvalid = 1'b0;
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata = memf(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata = 32'hDEAD_BEEF;
      end
   end

   // Reference model: outstanding requests as a queue of stale flags, buffer as a queue of {pc,data}.
   logic        m_run;
   logic [31:0] m_pc;
   logic [31:0] m_respc;
   bit          m_out[$];
   logic [63:0] m_fifo[$];
   logic [31:0] tgt;
   logic [31:0] e_addr;
   logic        e_credit;
   logic        do_pop;
   bit          was_stale;
   int          occ;

   always @(negedge clk) begin
      if (!rst_ni) begin
         m_run = 1'b0;
         m_pc = 32'h0;
         m_respc = 32'h0;
         m_out.delete();
         m_fifo.delete();
         check("reset_req_valid", mem_valid, 0);
         check("reset_inst_valid", inst_valid, 0);
      end else begin
         tgt = {redirect_pc[31:2], 2'b00};
         e_addr = redirect_valid ? tgt : m_pc;
         occ = m_out.size() + (redirect_valid ? 0 : m_fifo.size());
         e_credit = m_run && (occ < 4);
         check("req_valid", mem_valid, e_credit);
         check("req_addr", mem_addr, e_addr);
         check("write_zero", {mem_wdata, mem_wmask}, 0);
         check("inst_valid", inst_valid, m_fifo.size() != 0);
         if (m_fifo.size() != 0) check("inst_head", {inst_pc, inst_data}, m_fifo[0]);

         do_pop = !redirect_valid && (m_fifo.size() != 0) && inst_ready;
         if (do_pop) void'(m_fifo.pop_front());
         if (mem_rvalid && m_out.size() > 0) begin
            was_stale = m_out.pop_front();
            if (!redirect_valid && !was_stale) begin
               m_fifo.push_back({m_respc, memf(m_respc)});
               m_respc = m_respc + 32'd4;
            end
         end
         if (redirect_valid) begin
            m_fifo.delete();
            m_respc = tgt;
            foreach (m_out[i]) m_out[i] = 1'b1;
         end
         if (e_credit && mem_ready) begin
            m_out.push_back(1'b0);
            m_pc = e_addr + 32'd4;
         end else if (redirect_valid) begin
            m_pc = tgt;
         end
         m_run = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pc(input string nm, input logic [31:0] pc);
      int k = 0;
      while (!inst_valid && k < 20) begin
         tick(1);
         #1;
         k++;
      end
      check(nm, {inst_valid, inst_pc}, {1'b1, pc});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // Back-to-back stream straight out of reset
      inst_ready = 1'b1;
      tick(3);
      rst_ni = 1'b1;
      #1;
      check("pre_run_valid", mem_valid, 0);
      tick(1); #1;
      check("first_req", {mem_valid, mem_addr}, {1'b1, 32'h0});
      tick(1); #1;
      check("second_req", mem_addr, 32'h4);
      tick(1); #1;
      check("first_out", {inst_valid, inst_pc, inst_data}, {1'b1, 32'h0, 32'hC0DE_0000});
      tick(1); #1;
      check("second_out", {inst_valid, inst_pc, inst_data}, {1'b1, 32'h4, 32'hC0DA_000C});
      tick(6);

      // Asynchronous reset with several requests in flight
      lat = 3;
      tick(8);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_req_valid", mem_valid, 0);
      check("async_inst_valid", inst_valid, 0);
      lat = 1;
      inst_ready = 1'b0;
      tick(2);
      rst_ni = 1'b1;
      #1;
      check("release_req_valid", mem_valid, 0);
      check("release_inst_valid", inst_valid, 0);

      // Stalled consumer: credit caps at four
      tick(1); #1;
      check("t2_first_req", {mem_valid, mem_addr}, {1'b1, 32'h0});
      tick(10); #1;
      check("t2_full", {mem_valid, inst_valid, inst_pc}, {1'b0, 1'b1, 32'h0});
      inst_ready = 1'b1;
      tick(1);
      inst_ready = 1'b0;
      #1;
      check("t2_refill", {mem_valid, mem_addr, inst_pc}, {1'b1, 32'h10, 32'h4});

      // Redirect with responses outstanding at latency 3
      inst_ready = 1'b1;
      lat = 3;
      tick(3);
      redirect_valid = 1'b1;
      redirect_pc = 32'h101;
      #1;
      check("t3_redirect_addr", mem_addr, 32'h100);
      tick(1);
      redirect_valid = 1'b0;
      wait_pc("t3_first_out", 32'h100);

      // Redirect coinciding with a response and a pop
      lat = 1;
      tick(4);
      #1;
      k = 0;
      while (!(mem_rvalid && inst_valid) && k < 20) begin
         tick(1); #1;
         k++;
      end
      check("t4_setup", k < 20, 1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      tick(1);
      redirect_valid = 1'b0;
      #1;
      check("t4_flushed", inst_valid, 0);
      wait_pc("t4_first_out", 32'h40);

      // Memory stall with redirect mid-stall
      mem_ready = 1'b0;
      tick(2);
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      #1;
      check("t5_redirect", {mem_valid, mem_addr}, {1'b1, 32'h200});
      tick(1);
      redirect_valid = 1'b0;
      tick(2); #1;
      check("t5_hold", {mem_valid, mem_addr}, {1'b1, 32'h200});
      mem_ready = 1'b1;
      tick(1); #1;
      check("t5_after_accept", mem_addr, 32'h204);

      // PC wrap at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      #1;
      check("wrap_redirect", mem_addr, 32'hFFFF_FFFC);
      tick(1);
      redirect_valid = 1'b0;
      #1;
      check("wrap_next", mem_addr, 32'h0);
      wait_pc("wrap_out", 32'hFFFF_FFFC);
      tick(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
